mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares one single-port, word-wide, synchronous-read unified memory between the instruction-fetch port and the load/store data port of the core.
- Arbitrates every cycle, generates byte enables and store-data lane placement from mem_size_e, and extracts plus sign/zero-extends load data on the return cycle.
- Flags misaligned and out-of-range data accesses.
- Sits between the core datapath (PC/fetch logic, LSU) and the memory macro.

Parameters:
- XLEN, 32, data/address width (from riscv_pkg).
- MEM_WORDS, 1024, memory depth in 32-bit words.
- MAX_DATA_STREAK, 2, consecutive data grants allowed while fetch waits before fetch is forced.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- if_req_i  in  1  fetch request.
- if_addr_i  in  XLEN  fetch byte address (word aligned).
- if_gnt_o  out  1  fetch accepted this cycle.
- if_rvalid_o  out  1  fetch data valid.
- if_rdata_o  out  XLEN  fetched instruction.
- d_req_i  in  1  data request.
- d_we_i  in  1  1 = store, 0 = load.
- d_addr_i  in  XLEN  data byte address.
- d_size_i  in  2  mem_size_e.
- d_unsigned_i  in  1  zero-extend load (LBU/LHU).
- d_wdata_i  in  XLEN  store data, right-aligned.
- d_gnt_o  out  1  data request accepted this cycle.
- d_rvalid_o  out  1  data response (load data or store/err completion).
- d_rdata_o  out  XLEN  extended load data.
- d_err_o  out  1  misaligned/out-of-range, qualified by d_rvalid_o.
- mem_req_o  out  1  memory access enable.
- mem_we_o  out  1  memory write.
- mem_addr_o  out  $clog2(MEM_WORDS)  word address = byte_addr[..:2].
- mem_be_o  out  4  byte enables.
- mem_wdata_o  out  XLEN  lane-shifted store data.
- mem_rdata_i  in  XLEN  read data, valid the cycle after a read.

Behaviour:
- Reset state:
  - Every output reads 0 while rst_i is high and in the first cycle after release.
  - Response register = RESP_NONE; streak counter = 0.
- Grants:
  - Combinational, same cycle as the request; at most one grant per cycle.
  - A new grant is allowed every cycle (fully pipelined, one response in flight).
- Arbitration:
  - Data beats fetch, unless streak == MAX_DATA_STREAK and if_req_i is high; then fetch wins.
  - Streak counter: increments on each data grant while if_req_i is high; clears on a fetch grant or when if_req_i is low; saturates at MAX_DATA_STREAK.
- Response register, captured on grant:
  - Fields: owner (RESP_NONE, RESP_IF, RESP_LD, RESP_ST, RESP_ERR), byte offset addr[1:0], size, unsigned.
  - With no grant it returns to RESP_NONE.
- Latency: exactly 1 cycle from grant to rvalid for every granted request.
  - RESP_IF: if_rvalid_o = 1, if_rdata_o = mem_rdata_i.
  - RESP_LD: d_rvalid_o = 1, d_rdata_o = extract(mem_rdata_i >> 8*offset), sign-extended unless unsigned.
  - RESP_ST: d_rvalid_o = 1, d_rdata_o = 0.
  - RESP_ERR: d_rvalid_o = 1, d_err_o = 1, d_rdata_o = 0.
- Byte enables:
  - BYTE: 4'b0001 << off.
  - HALFW: 4'b0011 << off.
  - WORD: 4'b1111.
  - mem_be_o applies to stores only; it is 4'b1111 on reads.
  - mem_wdata_o = replicated lane data (byte ×4, half ×2).
- Errors. The request is still granted but mem_req_o stays 0 and the response is RESP_ERR when any of these holds:
  - HALFW with addr[0] = 1.
  - WORD with addr[1:0] != 0.
  - d_addr_i[XLEN-1:2] >= MEM_WORDS.
  - d_size_i = 2'b11.
- Fetch addresses are not checked; their upper bits are truncated.
- Idle cycle: mem_req_o = 0; the other mem_* outputs are don't-care and driven 0.
- Simultaneous events:
  - Both requests in the same cycle: the loser sees gnt = 0 and must hold its request stable.
  - Responding and granting in the same cycle is normal.
- Reset mid-operation: an in-flight response is discarded and no rvalid is produced after reset.

Decomposition:
- Add to riscv_pkg:
  - resp_owner_e (3-bit enum).
  - Struct resp_info_t {owner, off[1:0], size mem_size_e, uns}.
  - Localparam MAX_DATA_STREAK_DEF = 2.
- Reuse mem_size_e and XLEN from the package.
- One natural sub-module, lsu_lane_align:
  - Combinational store lane placement and byte-enable generation.
  - Load extraction and extension.
  - Misalignment check.

Test Plan:
- Fetch only, addr 0x10, mem word 4 = 0x00500093:
  - Cycle 0: if_gnt = 1, mem_addr = 4, mem_req = 1.
  - Cycle 1: if_rvalid = 1, if_rdata = 0x00500093.
- Store BYTE 0xA5 to 0x103:
  - mem_be = 4'b1000, mem_wdata = 0xA5A5A5A5, mem_addr = 0x40.
  - Next cycle: d_rvalid = 1, d_err = 0.
- Loads from word 0x40 = 0xA5000000:
  - LB 0x103 returns 0xFFFFFFA5.
  - LBU returns 0x000000A5.
  - LH 0x102 returns 0xFFFFA500.
- Misalignment and range:
  - LW at 0x102: gnt = 1, mem_req = 0; next cycle d_rvalid = 1, d_err = 1, d_rdata = 0.
  - SW at byte address 0x1000 (word 1024): same error response.
- Both ports requesting continuously:
  - Grant order is D, D, F, D, D, F…
  - A fetch never waits more than 2 cycles.
- rst_i asserted the cycle after a load grant:
  - No d_rvalid at any time.
  - All outputs are 0 during reset and in the first cycle after release.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared core types: data width, access sizes and the memory-port response descriptor.
package riscv_pkg;

  localparam int unsigned XLEN                = 32;
  localparam int unsigned MAX_DATA_STREAK_DEF = 2;

  typedef enum logic [1:0] {
    MEM_BYTE  = 2'b00,
    MEM_HALFW = 2'b01,
    MEM_WORD  = 2'b10
  } mem_size_e;

  typedef enum logic [2:0] {
    RESP_NONE = 3'd0,
    RESP_IF   = 3'd1,
    RESP_LD   = 3'd2,
    RESP_ST   = 3'd3,
    RESP_ERR  = 3'd4
  } resp_owner_e;

  typedef struct packed {
    resp_owner_e owner;
    logic [1:0]  off;
    mem_size_e   size;
    logic        uns;
  } resp_info_t;

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane handling: store placement and byte enables, alignment check,
// and load extraction with sign/zero extension on the return path.
module lsu_lane_align
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = riscv_pkg::XLEN
) (
  input  logic [1:0]      req_off,
  input  logic [1:0]      req_size,
  input  logic [XLEN-1:0] req_wdata,
  output logic [3:0]      req_be,
  output logic [XLEN-1:0] req_wdata_lane,
  output logic            req_misaligned,
  input  logic [1:0]      resp_off,
  input  mem_size_e       resp_size,
  input  logic            resp_uns,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] rdata_ext
);

  logic [XLEN-1:0] rdata_sh;

  always_comb begin
    req_be         = 4'b1111;
    req_wdata_lane = req_wdata;
    req_misaligned = 1'b0;
    case (req_size)
      MEM_BYTE: begin
        req_be         = 4'b0001 << req_off;
        req_wdata_lane = {(XLEN/8){req_wdata[7:0]}};
      end
      MEM_HALFW: begin
        req_be         = 4'b0011 << req_off;
        req_wdata_lane = {(XLEN/16){req_wdata[15:0]}};
        req_misaligned = req_off[0];
      end
      MEM_WORD: req_misaligned = (req_off != 2'b00);
      default:  req_misaligned = 1'b1;
    endcase
  end

  always_comb begin
    rdata_sh  = rdata >> {resp_off, 3'b000};
    rdata_ext = rdata_sh;
    case (resp_size)
      MEM_BYTE:  rdata_ext = {{(XLEN-8){~resp_uns & rdata_sh[7]}}, rdata_sh[7:0]};
      MEM_HALFW: rdata_ext = {{(XLEN-16){~resp_uns & rdata_sh[15]}}, rdata_sh[15:0]};
      default:   rdata_ext = rdata_sh;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous-read memory between instruction fetch and the load/store port,
// with bounded data priority and one-cycle responses.
module mem_port_arbiter
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN            = riscv_pkg::XLEN,
  parameter int unsigned MEM_WORDS       = 1024,
  parameter int unsigned MAX_DATA_STREAK = riscv_pkg::MAX_DATA_STREAK_DEF,
  localparam int unsigned AW             = $clog2(MEM_WORDS)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            if_req_i,
  input  logic [XLEN-1:0] if_addr_i,
  output logic            if_gnt_o,
  output logic            if_rvalid_o,
  output logic [XLEN-1:0] if_rdata_o,
  input  logic            d_req_i,
  input  logic            d_we_i,
  input  logic [XLEN-1:0] d_addr_i,
  input  logic [1:0]      d_size_i,
  input  logic            d_unsigned_i,
  input  logic [XLEN-1:0] d_wdata_i,
  output logic            d_gnt_o,
  output logic            d_rvalid_o,
  output logic [XLEN-1:0] d_rdata_o,
  output logic            d_err_o,
  output logic            mem_req_o,
  output logic            mem_we_o,
  output logic [AW-1:0]   mem_addr_o,
  output logic [3:0]      mem_be_o,
  output logic [XLEN-1:0] mem_wdata_o,
  input  logic [XLEN-1:0] mem_rdata_i
);

  localparam int unsigned SW = (MAX_DATA_STREAK > 0) ? $clog2(MAX_DATA_STREAK + 1) : 1;

  logic            ready_q;
  logic [SW-1:0]   streak_q, streak_d;
  resp_info_t      resp_q, resp_d;

  logic            force_if, if_gnt, d_gnt;
  logic            out_of_range, misaligned, d_err_req;
  logic [3:0]      be_lane;
  logic [XLEN-1:0] wdata_lane, rdata_ext;

  logic unused_if_addr;
  assign unused_if_addr = ^{if_addr_i[XLEN-1:AW+2], if_addr_i[1:0]};

  lsu_lane_align #(
    .XLEN (XLEN)
  ) u_align (
    .req_off        (d_addr_i[1:0]),
    .req_size       (d_size_i),
    .req_wdata      (d_wdata_i),
    .req_be         (be_lane),
    .req_wdata_lane (wdata_lane),
    .req_misaligned (misaligned),
    .resp_off       (resp_q.off),
    .resp_size      (resp_q.size),
    .resp_uns       (resp_q.uns),
    .rdata          (mem_rdata_i),
    .rdata_ext      (rdata_ext)
  );

  // ready_q masks every output during reset and for the first cycle after release.
  always_comb begin
    force_if     = if_req_i && (streak_q == SW'(MAX_DATA_STREAK));
    if_gnt       = ready_q && if_req_i && (!d_req_i || force_if);
    d_gnt        = ready_q && d_req_i && !if_gnt;
    out_of_range = d_addr_i[XLEN-1:2] >= (XLEN-2)'(MEM_WORDS);
    d_err_req    = misaligned || out_of_range;
  end

  always_comb begin
    streak_d = streak_q;
    if (if_gnt || !if_req_i) begin
      streak_d = '0;
    end else if (d_gnt && (streak_q < SW'(MAX_DATA_STREAK))) begin
      streak_d = streak_q + 1'b1;
    end
  end

  always_comb begin
    resp_d = '0;
    if (if_gnt) begin
      resp_d.owner = RESP_IF;
    end else if (d_gnt) begin
      resp_d.owner = d_err_req ? RESP_ERR : (d_we_i ? RESP_ST : RESP_LD);
      resp_d.off   = d_addr_i[1:0];
      resp_d.size  = mem_size_e'(d_size_i);
      resp_d.uns   = d_unsigned_i;
    end
  end

  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_be_o    = 4'b0000;
    mem_wdata_o = '0;
    if (if_gnt) begin
      mem_req_o  = 1'b1;
      mem_addr_o = if_addr_i[AW+1:2];
      mem_be_o   = 4'b1111;
    end else if (d_gnt && !d_err_req) begin
      mem_req_o   = 1'b1;
      mem_we_o    = d_we_i;
      mem_addr_o  = d_addr_i[AW+1:2];
      mem_be_o    = d_we_i ? be_lane : 4'b1111;
      mem_wdata_o = d_we_i ? wdata_lane : '0;
    end
  end

  always_comb begin
    if_rvalid_o = 1'b0;
    if_rdata_o  = '0;
    d_rvalid_o  = 1'b0;
    d_rdata_o   = '0;
    d_err_o     = 1'b0;
    if (ready_q) begin
      case (resp_q.owner)
        RESP_IF: begin
          if_rvalid_o = 1'b1;
          if_rdata_o  = mem_rdata_i;
        end
        RESP_LD: begin
          d_rvalid_o = 1'b1;
          d_rdata_o  = rdata_ext;
        end
        RESP_ST: d_rvalid_o = 1'b1;
        RESP_ERR: begin
          d_rvalid_o = 1'b1;
          d_err_o    = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign if_gnt_o = if_gnt;
  assign d_gnt_o  = d_gnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ready_q  <= 1'b0;
      streak_q <= '0;
      resp_q   <= '0;
    end else begin
      ready_q  <= 1'b1;
      streak_q <= streak_d;
      resp_q   <= resp_d;
    end
  end

endmodule
